// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
// Holds the controller state encoding, default sizing and byte-lane packing.
package dcache_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ_MISS,
      S_WRITE,
      S_DONE
   } dcache_state_t;

   localparam int DCACHE_LINES       = 16;
   localparam int DCACHE_MEM_LATENCY = 4;

   // lane0 carries the most significant byte
   function automatic logic [31:0] lanes_to_word(input logic [0:3][7:0] l);
      return {l[0], l[1], l[2], l[3]};
   endfunction

   function automatic logic [0:3][7:0] word_to_lanes(input logic [31:0] w);
      return {w[31:24], w[23:16], w[15:8], w[7:0]};
   endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays of the data cache with combinational lookup
// and one synchronous write port shared by fills and write-updates.
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int LINES = DCACHE_LINES,
   parameter int IDX_W = $clog2(LINES),
   parameter int TAG_W = XLEN - IDX_W - 2
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [IDX_W-1:0] idx,
   input  logic [TAG_W-1:0] tag,
   input  logic             we,
   input  logic [XLEN-1:0]  wdata,
   output logic             hit,
   output logic [XLEN-1:0]  rdata
);

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];
   logic [XLEN-1:0]  data [LINES];

   // valid bits clear on reset so every line misses afterwards
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)
         valid <= '0;
      else if (we)
         valid[idx] <= 1'b1;
   end

   // tag and data need no reset; they are qualified by valid
   always_ff @(posedge clk) begin
      if (we) begin
         tags[idx] <= tag;
         data[idx] <= wdata;
      end
   end

   // lookup at the current request address
   always_comb begin
      hit   = valid[idx] && (tags[idx] == tag);
      rdata = data[idx];
   end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-through no-write-allocate data cache controller.
// Optional DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int LINES       = DCACHE_LINES,
   parameter int MEM_LATENCY = DCACHE_MEM_LATENCY
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            halted,
   input  logic [XLEN-1:0] cpu_addr,
   input  logic            cpu_read,
   input  logic            cpu_write,
   input  logic [XLEN-1:0] cpu_wdata,
   output logic [XLEN-1:0] cpu_rdata,
   output logic            cpu_stall,
   output logic [XLEN-1:0] mem_addr,
   output logic [0:3][7:0] mem_data_in,
   input  logic [0:3][7:0] mem_data_out,
   output logic            mem_write_en
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]     hit_count,
   output logic [31:0]     miss_count
`endif
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = XLEN - IDX_W - 2;
   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   dcache_state_t    state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  word_q;
   logic             last;
   logic             accept;
   logic             st_hit;
   logic [XLEN-1:0]  st_rdata;
   logic             st_we;
   logic [XLEN-1:0]  st_wdata;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^cpu_addr[1:0];
   assign last   = (cnt == CNT_W'(MEM_LATENCY));
   // new requests are refused while halted or held in reset
   assign accept = rst_b && !halted;

   assign mem_addr    = {cpu_addr[XLEN-1:2], 2'b00};
   assign mem_data_in = word_to_lanes(cpu_wdata);

   dcache_line_store #(
      .XLEN  (XLEN),
      .LINES (LINES)
   ) u_store (
      .clk   (clk),
      .rst_b (rst_b),
      .idx   (cpu_addr[IDX_W+1:2]),
      .tag   (cpu_addr[XLEN-1:IDX_W+2]),
      .we    (st_we),
      .wdata (st_wdata),
      .hit   (st_hit),
      .rdata (st_rdata)
   );

   // state, latency counter and latched fill word
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state  <= S_IDLE;
         cnt    <= '0;
         word_q <= '0;
      end else begin
         state <= state_n;
         if (state_n == S_READ_MISS || state_n == S_WRITE)
            cnt <= cnt + 1'b1;
         else
            cnt <= '0;
         if (state == S_READ_MISS && last)
            word_q <= lanes_to_word(mem_data_out);
      end
   end

   // next state, stall, memory strobe and array write control
   always_comb begin
      state_n      = state;
      cpu_stall    = 1'b0;
      cpu_rdata    = '0;
      mem_write_en = 1'b0;
      st_we        = 1'b0;
      st_wdata     = cpu_wdata;
      unique case (state)
         S_IDLE: begin
            if (accept && cpu_write) begin
               cpu_stall = 1'b1;
               state_n   = S_WRITE;
            end else if (accept && cpu_read) begin
               if (st_hit) begin
                  cpu_rdata = st_rdata;
               end else begin
                  cpu_stall = 1'b1;
                  state_n   = S_READ_MISS;
               end
            end
         end
         S_READ_MISS: begin
            cpu_stall = 1'b1;
            if (last) begin
               st_we    = 1'b1;
               st_wdata = lanes_to_word(mem_data_out);
               state_n  = S_DONE;
            end
         end
         S_WRITE: begin
            cpu_stall    = 1'b1;
            mem_write_en = 1'b1;
            if (last) begin
               st_we   = st_hit;
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            cpu_rdata = word_q;
            state_n   = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

`ifdef DCACHE_STATS_EN
   logic rd_lookup;
   assign rd_lookup = (state == S_IDLE) && accept && !cpu_write && cpu_read;

   // saturating read hit/miss counters, sampled on the IDLE decision cycle
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (rd_lookup) begin
         if (st_hit && hit_count != 32'hFFFF_FFFF)
            hit_count <= hit_count + 32'd1;
         if (!st_hit && miss_count != 32'hFFFF_FFFF)
            miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule
